fetch_queue_stage: RTL

Parametrised next-generation instruction fetch stage. It owns the PC and drives the instruction memory address. Memory is combinational-read, so data returns in the same cycle. Each fetched word is pushed together with its PC into an internal instruction queue, which decouples fetch from decode through a valid/ready handshake. A branch redirect flushes the queue and reloads the PC.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_queue_stage_instr_queue.sv | 80 ++++++++
 rtl/fetch_queue_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and queue-entry layout for the instruction fetch stage.
// Imported by the queue, the stage top and the bench.
package fetch_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 32;
  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam int DEFAULT_PC_STEP     = 4;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  localparam logic [31:0] RESET_PC = 32'h0000_0010;

  // Queue entry for the default widths; the stage packs {pc, instr} in this order
  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0]  pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Width of the occupancy counter for a queue of the given depth
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_stage_instr_queue.sv
// Synchronous FIFO used as the fetch-to-decode instruction queue.
// Head is read combinationally; flush clears occupancy without touching storage.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy flags and guarded push/pop so the FIFO can never over- or underflow
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (pop && !empty_s) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (push && (!full_s || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Storage write; no reset needed since count gates visibility of every slot
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush && !reset) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the PC, captures same-cycle memory data into
// the instruction queue, and lets a branch redirect flush the queue and reload the PC.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] INITIAL_PC  = ADDR_WIDTH'(RESET_PC),
  parameter int                    PC_STEP     = DEFAULT_PC_STEP,
  parameter int                    QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        fst_in_branch_address,
  input  logic                         fst_in_branch_enable,
  input  logic [INSTR_WIDTH-1:0]       fst_in_instr,
  output logic [ADDR_WIDTH-1:0]        fst_out_instr_address,
  output logic                         fst_out_fetch_en,
  output logic [INSTR_WIDTH-1:0]       fst_out_instr,
  output logic [ADDR_WIDTH-1:0]        fst_out_instr_pc,
  output logic                         fst_out_valid,
  input  logic                         fst_in_ready,
  output logic [$clog2(QUEUE_DEPTH):0] fst_out_count
);

  localparam int CW = count_width(QUEUE_DEPTH);
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [CW-1:0]         count_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  fetch_en_s;
  logic [EW-1:0]         push_data_s;
  logic [EW-1:0]         head_s;

  // Handshake and fetch decision; a redirect suppresses both push and pop,
  // and a full queue still fetches when the head leaves this edge
  always_comb begin
    valid_s    = (count_s != {CW{1'b0}});
    pop_s      = 1'b0;
    fetch_en_s = 1'b0;
    if (valid_s && fst_in_ready && !fst_in_branch_enable) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (!reset && !fst_in_branch_enable &&
        ((count_s < CW'(QUEUE_DEPTH)) || pop_s)) begin
      fetch_en_s = 1'b1;
    end else begin
      fetch_en_s = 1'b0;
    end
  end

  // PC register: reset beats redirect, redirect beats sequential advance
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= INITIAL_PC;
    end else if (fst_in_branch_enable) begin
      pc_r <= fst_in_branch_address;
    end else if (fetch_en_s) begin
      pc_r <= pc_r + ADDR_WIDTH'(PC_STEP);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign push_data_s = {pc_r, fst_in_instr};

  instr_queue #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (fst_in_branch_enable),
    .push      (fetch_en_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign fst_out_instr_address = pc_r;
  assign fst_out_fetch_en      = fetch_en_s;
  assign fst_out_instr_pc      = head_s[EW-1 -: ADDR_WIDTH];
  assign fst_out_instr         = head_s[INSTR_WIDTH-1:0];
  assign fst_out_valid         = valid_s;
  assign fst_out_count         = count_s;

endmodule
